step_sequencer: RTL and testbench

Parametrised transaction step sequencer. It replaces the fixed three-bit step counter and hand-written done-select mux at the top level with one generic block. The block walks a configurable number of numbered steps. For each step it issues a start pulse, waits for that step's done, supports a per-run skip mask and auto-completing steps, and enforces a watchdog timeout with fault reporting. The step code drives the datapath and memory controller exactly as the transaction controller's step code does today.

---
 rtl/step_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_step_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// -----------------------------------------------------------------------------
// step_sequencer
//
// Generic transaction step sequencer. Walks steps 1..NUM_STEPS in order,
// issuing a one-cycle start pulse per step and waiting for that step's done
// level (or an automatic completion). Steps can be skipped per run, and a
// watchdog turns a stuck step into a FAULT that remembers the step code.
//
// Ports:
//   i_clock        system clock, rising edge
//   i_resetn       asynchronous active-low reset
//   i_start        begin a run (accepted in IDLE only)
//   i_abort        cancel a run / leave FAULT, back to IDLE
//   i_clear_fault  leave FAULT
//   i_skip_mask    bit i skips step i+1; latched when a start is accepted
//   i_done_step    level done per step; bit i belongs to step i+1
//   o_step         current step code, 0 when not running
//   o_step_start   one-cycle pulse on the first cycle of each step
//   o_busy         high in LAUNCH and WAIT
//   o_finished     one-cycle pulse when a run completes
//   o_fault        high while in FAULT
//   o_fault_step   step that timed out; held until the next accepted start
//   o_state        debug view of the FSM state
//
// Handshake: i_start is a level sampled on the clock edge; it is taken only
// while IDLE and otherwise dropped, there is no back-pressure signal.
// -----------------------------------------------------------------------------
module step_sequencer #(
    parameter int                   NUM_STEPS = 4,
    parameter int                   STEP_W    = 3,
    parameter logic [NUM_STEPS-1:0] AUTO_DONE = 4'b0100,
    parameter int                   TIMEOUT   = 1024,
    parameter int                   TMR_W     = 11
) (
    input  logic                 i_clock,
    input  logic                 i_resetn,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_clear_fault,
    input  logic [NUM_STEPS-1:0] i_skip_mask,
    input  logic [NUM_STEPS-1:0] i_done_step,
    output logic [STEP_W-1:0]    o_step,
    output logic                 o_step_start,
    output logic                 o_busy,
    output logic                 o_finished,
    output logic                 o_fault,
    output logic [STEP_W-1:0]    o_fault_step,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_FINISH = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [STEP_W-1:0]      r_step;
    logic [STEP_W-1:0]      r_fault_step;
    logic [NUM_STEPS-1:0]   r_mask;
    logic [TMR_W-1:0]       r_timer;
    logic                   r_step_start;
    logic                   r_busy;
    logic                   r_finished;
    logic                   r_fault;

    logic [NUM_STEPS-1:0]   w_sel;
    logic                   w_complete;
    logic                   w_timeout;
    logic [STEP_W-1:0]      w_first_step;
    logic [STEP_W-1:0]      w_next_step;

    // Lowest non-skipped step strictly above 'from'; 0 when none is left.
    function automatic logic [STEP_W-1:0] f_next_step(
        input logic [NUM_STEPS-1:0] mask,
        input logic [STEP_W-1:0]    from
    );
        logic [STEP_W-1:0] res;
        res = '0;
        for (int i = NUM_STEPS - 1; i >= 0; i--) begin
            if (!mask[i] && (STEP_W'(i + 1) > from)) begin
                res = STEP_W'(i + 1);
            end
        end
        return res;
    endfunction

    always_comb begin
        w_sel = '0;
        // One-hot decode of the step code replaces an index by step-1,
        // so step 0 (idle) selects nothing.
        for (int i = 0; i < NUM_STEPS; i++) begin
            w_sel[i] = (r_step == STEP_W'(i + 1));
        end
        w_complete   = |(w_sel & (i_done_step | AUTO_DONE));
        w_timeout    = (TIMEOUT != 0) && (r_timer == TMR_W'(TIMEOUT - 1));
        w_first_step = f_next_step(i_skip_mask, '0);
        w_next_step  = f_next_step(r_mask, r_step);
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state      <= S_IDLE;
            r_step       <= '0;
            r_fault_step <= '0;
            r_mask       <= '0;
            r_timer      <= '0;
            r_step_start <= 1'b0;
            r_busy       <= 1'b0;
            r_finished   <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_finished <= 1'b0;
                    if (i_start) begin
                        r_mask       <= i_skip_mask;
                        r_fault_step <= '0;
                        r_timer      <= '0;
                        if (w_first_step != '0) begin
                            r_state      <= S_LAUNCH;
                            r_step       <= w_first_step;
                            r_step_start <= 1'b1;
                            r_busy       <= 1'b1;
                        end else begin
                            r_state    <= S_FINISH;
                            r_finished <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_step_start <= 1'b0;
                    r_timer      <= '0;
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_step  <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        // done is deliberately not looked at here, so a level
                        // left over from the previous step cannot skip WAIT.
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_step  <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_complete) begin
                        r_timer <= '0;
                        if (w_next_step != '0) begin
                            r_state      <= S_LAUNCH;
                            r_step       <= w_next_step;
                            r_step_start <= 1'b1;
                        end else begin
                            r_state    <= S_FINISH;
                            r_step     <= '0;
                            r_busy     <= 1'b0;
                            r_finished <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state      <= S_FAULT;
                        r_fault_step <= r_step;
                        r_step       <= '0;
                        r_busy       <= 1'b0;
                        r_fault      <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state    <= S_IDLE;
                    r_finished <= 1'b0;
                end
                S_FAULT: begin
                    if (i_abort || i_clear_fault) begin
                        r_state <= S_IDLE;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_step       <= '0;
                    r_step_start <= 1'b0;
                    r_busy       <= 1'b0;
                    r_finished   <= 1'b0;
                    r_fault      <= 1'b0;
                end
            endcase
        end
    end

    assign o_step       = r_step;
    assign o_step_start = r_step_start;
    assign o_busy       = r_busy;
    assign o_finished   = r_finished;
    assign o_fault      = r_fault;
    assign o_fault_step = r_fault_step;
    assign o_state      = r_state;

endmodule

// File: tb/tb_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_step_sequencer
//
// Directed bench for step_sequencer with TIMEOUT=8. The driver works from the
// falling edge: it sets the inputs seen by the next rising edge and pushes the
// hand-computed output vector expected after that edge. A separate monitor
// pops one vector 2 time units after every rising edge and compares.
// Vector layout: {step[2:0], step_start, busy, finished, fault, fault_step[2:0]}.
// -----------------------------------------------------------------------------
module tb_step_sequencer;

    localparam int W = 10;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       clear_fault;
    logic [3:0] skip_mask;
    logic [3:0] done_step;
    logic [2:0] step;
    logic       step_start;
    logic       busy;
    logic       finished;
    logic       fault;
    logic [2:0] fault_step;
    logic [2:0] dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_vec;
    int           n_err;
    logic [2:0]   efs;

    step_sequencer #(
        .NUM_STEPS (4),
        .STEP_W    (3),
        .AUTO_DONE (4'b0100),
        .TIMEOUT   (8),
        .TMR_W     (11)
    ) dut (
        .i_clock       (clk),
        .i_resetn      (rst_n),
        .i_start       (start),
        .i_abort       (abort),
        .i_clear_fault (clear_fault),
        .i_skip_mask   (skip_mask),
        .i_done_step   (done_step),
        .o_step        (step),
        .o_step_start  (step_start),
        .o_busy        (busy),
        .o_finished    (finished),
        .o_fault       (fault),
        .o_fault_step  (fault_step),
        .o_state       (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic [2:0] s, input logic ss, input logic b,
                            input logic fin, input logic flt);
        exp_q.push_back({s, ss, b, fin, flt, efs});
        @(negedge clk);
    endtask

    task automatic t_launch(input logic [2:0] s); push_exp(s, 1'b1, 1'b1, 1'b0, 1'b0); endtask
    task automatic t_wait(input logic [2:0] s);   push_exp(s, 1'b0, 1'b1, 1'b0, 1'b0); endtask
    task automatic t_fin();                       push_exp(3'd0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic t_idle();                      push_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic t_fault();                     push_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

    // Immediate check of the reset values, used while resetn is low.
    task automatic check_reset(input string name);
        logic [W-1:0] act;
        act = {step, step_start, busy, finished, fault, fault_step};
        n_vec++;
        if (act !== '0) begin
            n_err++;
            $display("FAIL %s: got outputs=%b, expected %b", name, act, {W{1'b0}});
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] act;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {step, step_start, busy, finished, fault, fault_step};
                n_vec++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL vec%0d @%0t: got step=%0d ss=%b busy=%b fin=%b fault=%b fs=%0d, expected step=%0d ss=%b busy=%b fin=%b fault=%b fs=%0d",
                             n_vec, $time, act[9:7], act[6], act[5], act[4], act[3], act[2:0],
                             e[9:7], e[6], e[5], e[4], e[3], e[2:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        efs = 3'd0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        clear_fault = 1'b0;
        skip_mask = 4'b0000;
        done_step = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset_values");
        rst_n = 1'b1;

        // Full run, all done levels high: steps 1,1,2,2,3,3,4,4 then finished.
        done_step = 4'b1111;
        start = 1'b1; t_launch(3'd1);
        start = 1'b0; t_wait(3'd1);
        start = 1'b1; t_launch(3'd2);     // start while busy is ignored
        start = 1'b0; t_wait(3'd2);
        t_launch(3'd3);
        t_wait(3'd3);
        t_launch(3'd4);
        t_wait(3'd4);
        t_fin();
        start = 1'b1; t_idle();           // start in FINISH cycle ignored
        t_launch(3'd1);                   // start in following IDLE accepted
        start = 1'b0; abort = 1'b1; t_idle();   // abort in LAUNCH, no finished
        abort = 1'b0; t_idle();

        // Skip steps 1 and 2: step 3 completes by AUTO_DONE, step 4 waits for done.
        done_step = 4'b0000;
        skip_mask = 4'b0011;
        start = 1'b1; t_launch(3'd3);
        start = 1'b0; t_wait(3'd3);
        skip_mask = 4'b1111;              // mid-run mask change has no effect
        t_launch(3'd4);
        repeat (5) t_wait(3'd4);
        done_step = 4'b1000; t_fin();
        done_step = 4'b0000; t_idle();

        // Timeout on step 1: fault 9 cycles after step_start.
        skip_mask = 4'b0000;
        start = 1'b1; t_launch(3'd1);
        start = 1'b0;
        repeat (8) t_wait(3'd1);
        efs = 3'd1; t_fault();
        start = 1'b1; t_fault();          // start ignored in FAULT
        start = 1'b0; clear_fault = 1'b1; t_idle();
        clear_fault = 1'b0;

        // New start clears fault_step; done on the timeout cycle counts as completion.
        skip_mask = 4'b0010;
        start = 1'b1; efs = 3'd0; t_launch(3'd1);
        start = 1'b0;
        repeat (8) t_wait(3'd1);
        done_step = 4'b0001; t_launch(3'd3);   // step 2 skipped
        done_step = 4'b0000; t_wait(3'd3);
        t_launch(3'd4);
        done_step = 4'b1000; t_wait(3'd4);
        t_fin();
        done_step = 4'b0000; t_idle();

        // Abort together with done on the timeout cycle: back to IDLE, no finished.
        skip_mask = 4'b0000;
        start = 1'b1; t_launch(3'd1);
        start = 1'b0;
        repeat (8) t_wait(3'd1);
        done_step = 4'b0001; abort = 1'b1; t_idle();
        done_step = 4'b0000; abort = 1'b0; t_idle();

        // All steps skipped: finished one cycle after start, no step_start.
        skip_mask = 4'b1111;
        start = 1'b1; t_fin();
        start = 1'b0; t_idle();

        // Reset during WAIT of step 3, then a fresh run starts at step 1.
        skip_mask = 4'b0000;
        done_step = 4'b1011;
        start = 1'b1; t_launch(3'd1);
        start = 1'b0; t_wait(3'd1);
        t_launch(3'd2);
        t_wait(3'd2);
        t_launch(3'd3);
        done_step = 4'b0000; t_wait(3'd3);
        rst_n = 1'b0;
        #1;
        check_reset("async_reset_mid_run");
        @(negedge clk);
        check_reset("reset_held");
        rst_n = 1'b1;
        start = 1'b1; t_launch(3'd1);
        start = 1'b0; t_wait(3'd1);
        abort = 1'b1; t_idle();
        abort = 1'b0; t_idle();

        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending vectors, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
